// File: rtl/holo_cfg_pkg.sv
// holo_cfg_pkg: shared types and constants for the UART-to-SPI configuration
// controller.
//   - parse_state_t : UART frame parser states
//   - spi_state_t   : SPI write engine states
//   - SPI_WORD_W / ADDR_W / DATA_W : widths of the serialised write word
//   - FRAME_LEN     : bytes per frame, including the sync byte
//   - frame_csum()  : XOR checksum over the address and data bytes
// Optional feature macro: CFG_CHECKSUM_EN (adds the trailing checksum byte).
package holo_cfg_pkg;

  localparam int SPI_WORD_W = 24;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;

`ifdef CFG_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  // Encodings are ordered so that the last byte of a frame is received in
  // state number FRAME_LEN-1.
  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_ADDR = 3'd1,
    P_DHI  = 3'd2,
    P_DLO  = 3'd3
`ifdef CFG_CHECKSUM_EN
    ,
    P_CSUM = 3'd4
`endif
  } parse_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } spi_state_t;

  function automatic logic [7:0] frame_csum(input logic [7:0] addr,
                                            input logic [7:0] d_hi,
                                            input logic [7:0] d_lo);
    return addr ^ d_hi ^ d_lo;
  endfunction

endpackage

// File: rtl/spi_cfg_shifter.sv
// spi_cfg_shifter: 3-wire SPI write engine (mode 0, MSB first) with its own
// CLK_DIV prescaler. One transfer: LEAD (SEN low, bit 23 on SDAT) for CLK_DIV
// cycles, 24 bits of SCK high/low CLK_DIV cycles each, then SEN high for a
// CLK_DIV-cycle GAP before returning to IDLE.
//
// Handshake: o_ready is high exactly while the engine is in S_IDLE. i_load is
// a one-cycle strobe that is honoured only when o_ready is high; i_word is
// captured on that edge, SEN falls on the same edge, and o_ready stays low
// until the gap has finished. i_load while o_ready is low is ignored.
//
// Ports:
//   i_clock, i_reset     clock, synchronous active-high reset
//   i_load, i_word       load strobe and 24-bit {addr, data} word
//   o_ready              engine idle, may be loaded this cycle
//   o_finish             last cycle of the gap (engine idle next cycle)
//   o_sen, o_sck, o_sdat SPI pins (registered)
//   o_state              current engine state (debug)
module spi_cfg_shifter
  import holo_cfg_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [SPI_WORD_W-1:0] i_word,
  output logic                  o_ready,
  output logic                  o_finish,
  output logic                  o_sen,
  output logic                  o_sck,
  output logic                  o_sdat,
  output logic [1:0]            o_state
);

  localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [4:0]       TOP_BIT  = 5'(SPI_WORD_W - 1);

  spi_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [SPI_WORD_W-1:0] shreg;
  logic [4:0]            bit_idx;
  logic                  phase_end;

  assign phase_end = (cnt == CNT_LAST);
  assign o_ready   = (state == S_IDLE);
  assign o_finish  = (state == S_GAP) && phase_end;
  assign o_state   = state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      o_sen   <= 1'b1;
      o_sck   <= 1'b0;
      o_sdat  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_load) begin
            state   <= S_LEAD;
            cnt     <= '0;
            shreg   <= i_word;
            bit_idx <= TOP_BIT;
            o_sen   <= 1'b0;
            o_sdat  <= i_word[SPI_WORD_W-1];
          end
        end
        S_LEAD: begin
          if (phase_end) begin
            cnt   <= '0;
            state <= S_SHIFT;
            o_sck <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (!phase_end) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (o_sck) begin
              // Falling edge: present the next bit; bit 0 is held through
              // its low half.
              o_sck <= 1'b0;
              if (bit_idx != 5'd0) begin
                o_sdat <= shreg[bit_idx - 5'd1];
              end
            end else if (bit_idx == 5'd0) begin
              state  <= S_GAP;
              o_sen  <= 1'b1;
              o_sdat <= 1'b0;
            end else begin
              bit_idx <= bit_idx - 5'd1;
              o_sck   <= 1'b1;
            end
          end
        end
        S_GAP: begin
          if (phase_end) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_spi_cfg_ctrl.sv
// uart_spi_cfg_ctrl: parses framed register writes from the PC UART byte
// stream (SYNC, ADDR, DATA_HI, DATA_LO [, CSUM]) and hands each one to the
// SPI engine as a 24-bit {addr, data} write. A one-entry pending buffer
// holds a frame that arrives while the engine is busy; a frame arriving
// while the buffer is full is dropped and flagged in o_overflow.
// Optional feature macro: CFG_CHECKSUM_EN (5-byte frames, XOR checksum).
//
// Ports:
//   i_clock, i_reset     sys_clk, synchronous active-high reset
//   i_rx_dv, i_rx_byte   UART RX byte strobe and byte
//   i_clear_flags        clears o_overflow (a coincident overflow wins)
//   o_sen, o_sck, o_sdat SPI configuration port
//   o_busy               engine active or pending buffer occupied (registered)
//   o_frame_ok           pulse: frame accepted (loaded or buffered)
//   o_frame_err          pulse: checksum mismatch or inter-byte timeout
//   o_overflow           sticky: a frame was dropped, buffer was full
//   o_parser_state       parser state (debug)
//   o_spi_state          SPI engine state (debug)
module uart_spi_cfg_ctrl
  import holo_cfg_pkg::*;
#(
  parameter int         CLK_DIV      = 4,
  parameter int         BYTE_TIMEOUT = 100000,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  input  logic       i_clear_flags,
  output logic       o_sen,
  output logic       o_sck,
  output logic       o_sdat,
  output logic       o_busy,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic       o_overflow,
  output logic [2:0] o_parser_state,
  output logic [1:0] o_spi_state
);

  localparam int                 TMO_W      = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(BYTE_TIMEOUT);
  localparam parse_state_t       LAST_STATE = parse_state_t'(3'(FRAME_LEN - 1));

  parse_state_t          p_state;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W/2-1:0]   dhi_q;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  buf_full;
  logic [SPI_WORD_W-1:0] buf_word;

  logic                  eng_ready;
  logic                  eng_finish;
  logic                  eng_load;
  logic [SPI_WORD_W-1:0] eng_word;

  logic                  frame_last;
  logic                  frame_good;
  logic                  frame_bad;
  logic [SPI_WORD_W-1:0] frame_word;
  logic                  timeout_hit;
  logic                  load_buf;
  logic                  load_new;
  logic                  store_new;
  logic                  drop_new;
  logic                  buf_full_next;
  logic                  eng_busy_next;

  assign frame_last = i_rx_dv && (p_state == LAST_STATE);

`ifdef CFG_CHECKSUM_EN
  logic [DATA_W/2-1:0] dlo_q;

  assign frame_good = frame_last && (i_rx_byte == frame_csum(addr_q, dhi_q, dlo_q));
  assign frame_bad  = frame_last && !frame_good;
  assign frame_word = {addr_q, dhi_q, dlo_q};
`else
  // Without a checksum the final byte is the data low byte, taken straight
  // from the UART so the engine can load in the same cycle.
  assign frame_good = frame_last;
  assign frame_bad  = 1'b0;
  assign frame_word = {addr_q, dhi_q, i_rx_byte};
`endif

  // A byte arriving in the expiry cycle keeps the frame alive.
  assign timeout_hit = (p_state != P_IDLE) && !i_rx_dv && (tmo_cnt == TMO_LAST);

  // Routing. The buffered frame always has priority for the engine; a new
  // frame completing in that cycle takes the slot being vacated.
  assign load_buf      = eng_ready && buf_full;
  assign load_new      = frame_good && eng_ready && !buf_full;
  assign store_new     = frame_good && !load_new && (!buf_full || load_buf);
  assign drop_new      = frame_good && buf_full && !load_buf;
  assign eng_load      = load_buf || load_new;
  assign eng_word      = load_buf ? buf_word : frame_word;
  assign buf_full_next = store_new || (buf_full && !load_buf);
  assign eng_busy_next = eng_load || (!eng_ready && !eng_finish);

  assign o_parser_state = p_state;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      p_state     <= P_IDLE;
      addr_q      <= '0;
      dhi_q       <= '0;
`ifdef CFG_CHECKSUM_EN
      dlo_q       <= '0;
`endif
      tmo_cnt     <= '0;
      buf_full    <= 1'b0;
      buf_word    <= '0;
      o_busy      <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_frame_ok  <= frame_good && !drop_new;
      o_frame_err <= frame_bad || timeout_hit;
      o_busy      <= eng_busy_next || buf_full_next;
      buf_full    <= buf_full_next;
      if (store_new) begin
        buf_word <= frame_word;
      end

      if (drop_new) begin
        o_overflow <= 1'b1;
      end else if (i_clear_flags) begin
        o_overflow <= 1'b0;
      end

      if (i_rx_dv || p_state == P_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_LAST) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (timeout_hit) begin
        p_state <= P_IDLE;
      end else if (i_rx_dv) begin
        case (p_state)
          P_IDLE: begin
            if (i_rx_byte == SYNC_BYTE) begin
              p_state <= P_ADDR;
            end
          end
          P_ADDR: begin
            addr_q  <= i_rx_byte;
            p_state <= P_DHI;
          end
          P_DHI: begin
            dhi_q   <= i_rx_byte;
            p_state <= P_DLO;
          end
`ifdef CFG_CHECKSUM_EN
          P_DLO: begin
            dlo_q   <= i_rx_byte;
            p_state <= P_CSUM;
          end
          P_CSUM:  p_state <= P_IDLE;
`else
          P_DLO:   p_state <= P_IDLE;
`endif
          default: p_state <= P_IDLE;
        endcase
      end
    end
  end

  spi_cfg_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_load   (eng_load),
    .i_word   (eng_word),
    .o_ready  (eng_ready),
    .o_finish (eng_finish),
    .o_sen    (o_sen),
    .o_sck    (o_sck),
    .o_sdat   (o_sdat),
    .o_state  (o_spi_state)
  );

endmodule

// File: tb/tb_uart_spi_cfg_ctrl.sv
// Bench for uart_spi_cfg_ctrl. Directed frames are sent over the UART strobe
// interface; each frame expected on the SPI pins is pushed to exp_q, and a
// negedge monitor rebuilds every SPI word from SCK rising edges and compares
// it (plus bit count and SEN-low length) against the queue head.
module tb_uart_spi_cfg_ctrl;

  localparam int CLK_DIV      = 4;
  localparam int BYTE_TIMEOUT = 200;
  localparam int SEN_LOW      = 49 * CLK_DIV;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       clear_flags = 1'b0;
  logic       sen, sck, sdat, busy, frame_ok, frame_err, overflow;
  logic [2:0] parser_state;
  logic [1:0] spi_state;

  always #5 clock = ~clock;

  uart_spi_cfg_ctrl #(
    .CLK_DIV      (CLK_DIV),
    .BYTE_TIMEOUT (BYTE_TIMEOUT),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_rx_dv        (rx_dv),
    .i_rx_byte      (rx_byte),
    .i_clear_flags  (clear_flags),
    .o_sen          (sen),
    .o_sck          (sck),
    .o_sdat         (sdat),
    .o_busy         (busy),
    .o_frame_ok     (frame_ok),
    .o_frame_err    (frame_err),
    .o_overflow     (overflow),
    .o_parser_state (parser_state),
    .o_spi_state    (spi_state)
  );

  int          errors = 0;
  int          checks = 0;
  logic [23:0] exp_q[$];

  // Monitor state
  int          ok_pulses = 0;
  int          err_pulses = 0;
  int          sck_rises = 0;
  int          bit_cnt = 0;
  int          sen_low_cnt = 0;
  int          sen_high_cnt = 0;
  bit          have_prev = 1'b0;
  bit          aborting = 1'b0;
  logic        prev_sck = 1'b0;
  logic        prev_sen = 1'b1;
  logic [23:0] cap_word = '0;
  logic [23:0] exp_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: sampled on the falling clock edge.
  always @(negedge clock) begin
    if (frame_ok === 1'b1) ok_pulses++;
    if (frame_err === 1'b1) err_pulses++;
    if (sen === 1'b0) begin
      if (prev_sen) begin
        if (have_prev) begin
          checks++;
          if (sen_high_cnt < CLK_DIV) begin
            errors++;
            $display("FAIL sen_gap: got %0d high cycles, need >= %0d", sen_high_cnt, CLK_DIV);
          end
        end
        sen_low_cnt = 0;
        bit_cnt = 0;
        cap_word = '0;
      end
      sen_low_cnt++;
      if (sck && !prev_sck) begin
        cap_word = {cap_word[22:0], sdat};
        bit_cnt++;
      end
    end else begin
      if (!prev_sen) begin
        if (aborting) begin
          aborting = 1'b0;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spi_unexpected: got word 0x%06h, queue empty", cap_word);
        end else begin
          exp_word = exp_q.pop_front();
          check("spi_word", cap_word, exp_word);
          check("spi_bits", bit_cnt, 24);
          check("sen_low_cycles", sen_low_cnt, SEN_LOW);
        end
        have_prev = 1'b1;
        sen_high_cnt = 0;
      end
      sen_high_cnt++;
    end
    if (sck === 1'b1 && prev_sck === 1'b0) sck_rises++;
    prev_sck = sck;
    prev_sen = sen;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Returns on the negedge just after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clock);
    rx_dv   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(dh);
    send_byte(dl);
`ifdef CFG_CHECKSUM_EN
    send_byte(a ^ dh ^ dl);
`endif
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s: got busy=1 after %0d cycles, expected idle", name, budget);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_ok;
    int base_err;
    int snap;
    int n;

    // Reset state
    reset = 1'b1;
    tick(3);
    check("rst_sen", sen, 1);
    check("rst_sck", sck, 0);
    check("rst_sdat", sdat, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_parser_state", parser_state, 0);
    check("rst_spi_state", spi_state, 0);
    reset = 1'b0;
    tick(2);

    // Single valid write: A5 12 34 56 -> 0x123456
    base_ok = ok_pulses;
    exp_q.push_back(24'h123456);
    send_frame(8'h12, 8'h34, 8'h56);
    check("valid_frame_ok", frame_ok, 1);
    check("valid_sen_fall_with_ok", sen, 0);
    check("valid_busy", busy, 1);
    wait_idle("valid_idle", 400);
    check("valid_ok_count", ok_pulses - base_ok, 1);

`ifdef CFG_CHECKSUM_EN
    // Checksum mismatch: 12^34^56 = 70, send 71
    base_ok = ok_pulses;
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h71);
    check("csum_frame_err", frame_err, 1);
    check("csum_frame_ok", frame_ok, 0);
    check("csum_sen", sen, 1);
    tick(20);
    check("csum_sen_later", sen, 1);
    check("csum_ok_count", ok_pulses - base_ok, 0);
    check("csum_busy", busy, 0);
`endif

    // Inter-byte timeout, then a normal frame
    base_err = err_pulses;
    send_byte(8'hA5);
    send_byte(8'h12);
    tick(BYTE_TIMEOUT + 20);
    check("tmo_err_count", err_pulses - base_err, 1);
    check("tmo_parser_idle", parser_state, 0);
    base_ok = ok_pulses;
    exp_q.push_back(24'hABCDEF);
    send_frame(8'hAB, 8'hCD, 8'hEF);
    check("tmo_next_frame_ok", frame_ok, 1);
    wait_idle("tmo_idle", 400);
    check("tmo_next_ok_count", ok_pulses - base_ok, 1);

    // Noise before sync is ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("noise_parser_idle", parser_state, 0);
    base_ok = ok_pulses;
    exp_q.push_back(24'h010203);
    send_frame(8'h01, 8'h02, 8'h03);
    check("noise_frame_ok", frame_ok, 1);
    wait_idle("noise_idle", 400);
    check("noise_ok_count", ok_pulses - base_ok, 1);

    // Three frames back-to-back: 1 loads, 2 buffers, 3 is dropped
    base_ok = ok_pulses;
    exp_q.push_back(24'h214321);
    exp_q.push_back(24'h228765);
    send_frame(8'h21, 8'h43, 8'h21);
    check("b2b_f1_ok", frame_ok, 1);
    send_frame(8'h22, 8'h87, 8'h65);
    check("b2b_f2_ok", frame_ok, 1);
    check("b2b_f2_busy", busy, 1);
    check("b2b_f2_overflow", overflow, 0);
    send_frame(8'h23, 8'hBE, 8'hEF);
    check("b2b_f3_ok", frame_ok, 0);
    check("b2b_f3_overflow", overflow, 1);
    wait_idle("b2b_idle", 1000);
    check("b2b_ok_count", ok_pulses - base_ok, 2);
    check("b2b_overflow_sticky", overflow, 1);
    clear_flags = 1'b1;
    tick(1);
    clear_flags = 1'b0;
    check("b2b_overflow_cleared", overflow, 0);

    // Reset in the middle of a transfer
    aborting = 1'b1;
    send_frame(8'h5A, 8'hA5, 8'h3C);
    n = 0;
    while (bit_cnt < 10 && n < 300) begin
      tick(1);
      n++;
    end
    check("abort_reached_bit10", (bit_cnt >= 10) ? 1 : 0, 1);
    reset = 1'b1;
    tick(1);
    check("abort_sen", sen, 1);
    check("abort_sck", sck, 0);
    check("abort_busy", busy, 0);
    check("abort_spi_state", spi_state, 0);
    reset = 1'b0;
    snap = sck_rises;
    tick(100);
    check("abort_no_sck_edges", sck_rises - snap, 0);
    check("abort_sen_later", sen, 1);

    // Recovery after reset
    exp_q.push_back(24'h9ABCDE);
    send_frame(8'h9A, 8'hBC, 8'hDE);
    check("recover_frame_ok", frame_ok, 1);
    wait_idle("recover_idle", 400);
    tick(5);

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_spi_cfg_ctrl.md
Name: uart_spi_cfg_ctrl

Overview:
Configuration controller between the PC UART receiver and the 3-wire SPI configuration port of the display driver. It parses framed register-write commands from the received byte stream and serialises each one as a 24-bit SPI write (8-bit address, 16-bit data). A one-entry pending buffer decouples UART arrival from SPI transfer timing. Runs entirely in the sys_clk domain and is instantiated in top next to pc_rx.

Parameters:
CLK_DIV, 4, sys_clk cycles per SCK half-period (≥2)
BYTE_TIMEOUT, 100000, max sys_clk cycles between bytes of one frame
SYNC_BYTE, 8'hA5, frame start marker

Ports:
i_clock  in  1  system clock (sys_clk)
i_reset  in  1  synchronous, active-high reset
i_rx_dv  in  1  one-cycle strobe from UART RX: byte valid
i_rx_byte  in  8  received byte, valid with i_rx_dv
i_clear_flags  in  1  clears o_overflow
o_sen  out  1  SPI enable, active low
o_sck  out  1  SPI clock
o_sdat  out  1  SPI data, MSB first
o_busy  out  1  engine transferring, or pending buffer occupied
o_frame_ok  out  1  one-cycle pulse: frame accepted
o_frame_err  out  1  one-cycle pulse: checksum error or timeout
o_overflow  out  1  sticky: frame dropped because buffer full

Behaviour:
- Clocking and reset: one clock, i_clock. Reset is synchronous and active-high on i_reset.
- Reset values: o_sen=1, o_sck=0, o_sdat=0, o_busy=0, o_frame_ok=0, o_frame_err=0, o_overflow=0. The parser returns to P_IDLE and the pending buffer is emptied.
- Reset mid-transfer: the transfer is aborted. o_sen is 1 on the first edge after reset; no partial completion.
- Parser FSM: P_IDLE -> P_ADDR -> P_DHI -> P_DLO [-> P_CSUM] -> P_IDLE. It advances only on i_rx_dv.
  - P_IDLE: only SYNC_BYTE advances; any other byte is ignored silently.
  - A SYNC_BYTE received in a later state is treated as data.
- Timeout: a counter is cleared on each i_rx_dv. If it reaches BYTE_TIMEOUT while not in P_IDLE, the partial frame is discarded, o_frame_err pulses, and the parser goes to P_IDLE.
- Frame complete: o_frame_ok pulses in the cycle after the final byte's i_rx_dv. The frame is then routed as follows:
  - Engine idle and buffer empty: engine loads; o_sen falls on the same cycle as o_frame_ok.
  - Engine busy and buffer empty: frame is stored in the buffer.
  - Buffer full: frame is dropped, o_overflow is set, o_frame_ok does not pulse.
- o_overflow stays set until i_clear_flags or reset. If i_clear_flags coincides with a new overflow, the set wins.
- SPI engine states: S_IDLE, S_LEAD, S_SHIFT, S_GAP.
  - Word: {addr[7:0], data[15:0]}, 24 bits, mode 0.
  - S_LEAD: o_sen=0, o_sdat=bit23, held for CLK_DIV cycles.
  - S_SHIFT: per bit, o_sck high for CLK_DIV cycles, then low for CLK_DIV cycles. o_sdat changes only on the SCK falling edge.
  - After bit 0's low half: o_sen=1, o_sdat=0.
  - S_GAP: o_sen held high for CLK_DIV cycles.
- Transfer timing: o_sen is low for exactly 49*CLK_DIV cycles. The engine is busy for 50*CLK_DIV cycles in total (200 at default).
- Back-to-back: on leaving S_GAP, a full buffer loads the engine the next cycle and the buffer is freed in that same cycle. A frame completing in that same cycle is stored, not dropped.
- o_busy = (engine != S_IDLE) | buffer_full. It is registered.

Optional Feature:
CFG_CHECKSUM_EN.
- Defined: the frame is 5 bytes. The final byte must equal addr^dhi^dlo. On mismatch: o_frame_err pulses, the frame is discarded, and buffer/engine are unaffected.
- Undefined: the frame is 4 bytes, P_CSUM is absent, and o_frame_err pulses only on timeout.

Decomposition:
- Package holo_cfg_pkg: parser and SPI state enums, SPI_WORD_W=24, ADDR_W=8, DATA_W=16, FRAME_LEN (4 or 5 per macro).
- Sub-module spi_cfg_shifter: SPI engine plus CLK_DIV prescaler. It has a load/ready handshake; parser and buffer stay in the top-level controller.

Test Plan:
- Valid write: bytes A5,12,34,56 (+70 if CFG_CHECKSUM_EN), CLK_DIV=4 -> one o_frame_ok; o_sen low 196 cycles; SCK sampled on rising edges yields 0x123456.
- Checksum mismatch (CFG_CHECKSUM_EN): A5,12,34,56,71 -> o_frame_err pulse; o_sen stays high; o_frame_ok stays 0.
- Timeout: A5,12, then no bytes for BYTE_TIMEOUT cycles -> o_frame_err pulse; a following full valid frame is accepted normally.
- Three frames back-to-back at 115200 with CLK_DIV=4000 -> frames 1 and 2 transfer in order with a ≥CLK_DIV SEN-high gap; frame 3 is dropped; o_overflow=1 until i_clear_flags.
- Noise bytes 00,FF,5A before a sync -> ignored; the subsequent frame is transferred correctly.
- Reset asserted at bit 10 of a transfer -> the next edge gives o_sen=1, o_sck=0, o_busy=0, and no further SCK edges.
